// File: rtl/gpu_lram_pkg.sv
// Shared constants and packed-bus slice helpers for the GPU local RAM arbiter.
package gpu_lram_pkg;

  localparam logic [1:0] RQ_IO = 2'd0;
  localparam logic [1:0] RQ_LS = 2'd1;
  localparam logic [1:0] RQ_PF = 2'd2;
  localparam logic [1:0] RQ_BL = 2'd3;

  localparam int NUM_RQ       = 4;
  localparam int DATA_W       = 32;
  localparam int BE_W         = 4;
  localparam int ADDR_W_DEF   = 10;
  localparam int MAX_WAIT_DEF = 8;

  function automatic int addr_lo(input logic [1:0] id, input int aw);
    return int'(id) * aw;
  endfunction

  function automatic int data_lo(input logic [1:0] id);
    return int'(id) * DATA_W;
  endfunction

  function automatic int be_lo(input logic [1:0] id);
    return int'(id) * BE_W;
  endfunction

endpackage

// File: rtl/gpu_lram_age.sv
// Saturating 4-bit wait counter; aged flags a requester that has waited MAX_WAIT cycles.
module gpu_lram_age #(
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic       aged
);

  localparam logic [3:0] SAT = 4'(MAX_WAIT);

  logic [3:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc && count != SAT) begin
      count <= count + 4'd1;
    end
  end

  assign aged = (count == SAT);

endmodule

// File: rtl/gpu_lram_arb.sv
// Four-way arbiter for the single-port GPU local RAM: IO, load/store, prefetch, blitter.
module gpu_lram_arb
  import gpu_lram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic [3:0]            req,
  input  logic [3:0]            we,
  input  logic                  lock,
  input  logic [4*ADDR_W-1:0]   addr,
  input  logic [127:0]          wdata,
  input  logic [15:0]           be,
  output logic [3:0]            ack,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [3:0]            ram_be,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            rvalid,
  output logic [1:0]            grant_id
);

  logic        locked_q;
  logic        rr_q;        // 1 = BL has the round-robin turn, 0 = PF
  logic        pf_aged, bl_aged;
  logic        win_valid;
  logic [1:0]  win_id;
  logic [1:0]  rr_pick;
  logic        win_wr;

  gpu_lram_age #(.MAX_WAIT(MAX_WAIT)) u_age_pf (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .inc   (req[RQ_PF] & ~ack[RQ_PF]),
    .clr   (~req[RQ_PF] | ack[RQ_PF]),
    .aged  (pf_aged)
  );

  gpu_lram_age #(.MAX_WAIT(MAX_WAIT)) u_age_bl (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .inc   (req[RQ_BL] & ~ack[RQ_BL]),
    .clr   (~req[RQ_BL] | ack[RQ_BL]),
    .aged  (bl_aged)
  );

  assign rr_pick = rr_q ? RQ_BL : RQ_PF;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    win_valid = 1'b0;
    win_id    = RQ_IO;
    if (reset_n) begin
      win_valid = 1'b1;
      if (locked_q && req[RQ_LS])                                      win_id = RQ_LS;
      else if (req[RQ_IO])                                             win_id = RQ_IO;
      else if (pf_aged && req[RQ_PF] && bl_aged && req[RQ_BL])         win_id = rr_pick;
      else if (pf_aged && req[RQ_PF])                                  win_id = RQ_PF;
      else if (bl_aged && req[RQ_BL])                                  win_id = RQ_BL;
      else if (req[RQ_LS])                                             win_id = RQ_LS;
      else if (req[RQ_PF] && req[RQ_BL])                               win_id = rr_pick;
      else if (req[RQ_PF])                                             win_id = RQ_PF;
      else if (req[RQ_BL])                                             win_id = RQ_BL;
      else                                                             win_valid = 1'b0;
    end
  end

  assign ack    = win_valid ? 4'(4'b0001 << win_id) : 4'b0000;
  assign win_wr = win_valid && (win_id != RQ_PF) && we[win_id];

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= 4'h0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      rvalid    <= 4'b0000;
      grant_id  <= RQ_IO;
      locked_q  <= 1'b0;
      rr_q      <= 1'b0;
    end else begin
      // Only a first-beat LS grant can arm the lock; the locked beat never re-arms it.
      locked_q <= win_valid && (win_id == RQ_LS) && lock && !locked_q;
      if (win_valid && (win_id == RQ_PF || win_id == RQ_BL))
        rr_q <= (win_id == RQ_PF);
      rvalid <= (ram_cs && !ram_we) ? 4'(4'b0001 << grant_id) : 4'b0000;
      ram_cs <= win_valid;
      if (win_valid) begin
        ram_we    <= win_wr;
        ram_be    <= win_wr ? be[be_lo(win_id) +: 4] : 4'hF;
        ram_addr  <= addr[addr_lo(win_id, ADDR_W) +: ADDR_W];
        ram_wdata <= wdata[data_lo(win_id) +: 32];
        grant_id  <= win_id;
      end else begin
        ram_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpu_lram_arb.sv
// Directed bench for gpu_lram_arb: hand-computed grant, RAM-command and read-return vectors.
module tb_gpu_lram_arb;
  import gpu_lram_pkg::*;

  localparam int AW = 10;

  logic          sys_clk = 1'b0;
  logic          reset_n;
  logic [3:0]    req, we;
  logic          lock;
  logic [4*AW-1:0] addr;
  logic [127:0]  wdata;
  logic [15:0]   be;
  logic [3:0]    ack;
  logic          ram_cs, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    rvalid;
  logic [1:0]    grant_id;

  int vectors    = 0;
  int miscompares = 0;

  gpu_lram_arb #(.ADDR_W(AW), .MAX_WAIT(8)) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .ack       (ack),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .rvalid    (rvalid),
    .grant_id  (grant_id)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic mid_cyc();
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    req = 4'b0000; we = 4'b0000; lock = 1'b0;
    for (int i = 0; i < n; i++) next_cyc();
  endtask

  initial begin
    logic [3:0] exp_ack;

    reset_n = 1'b0;
    req = 4'b1111; we = 4'b0000; lock = 1'b0;
    addr = '0; wdata = '0; be = '0;

    // Reset state: no ack while in reset, all RAM registers cleared.
    #3;
    check("rst_ack",      32'(ack),      32'h0);
    check("rst_ram_cs",   32'(ram_cs),   32'h0);
    check("rst_ram_we",   32'(ram_we),   32'h0);
    check("rst_ram_be",   32'(ram_be),   32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_rvalid",   32'(rvalid),   32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    reset_n = 1'b1;
    req = 4'b0000;

    // IO read of 0x012 alone.
    next_cyc();
    req = 4'b0001; addr[RQ_IO*AW +: AW] = 10'h012;
    mid_cyc(); check("io_ack_c0", 32'(ack), 32'h1);
    next_cyc(); req = 4'b0000;
    mid_cyc();
    check("io_cs_c1",     32'(ram_cs),   32'h1);
    check("io_addr_c1",   32'(ram_addr), 32'h012);
    check("io_we_c1",     32'(ram_we),   32'h0);
    check("io_be_c1",     32'(ram_be),   32'hF);
    check("io_rvalid_c1", 32'(rvalid),   32'h0);
    next_cyc(); mid_cyc();
    check("io_rvalid_c2", 32'(rvalid),   32'h1);
    check("io_cs_c2",     32'(ram_cs),   32'h0);
    check("io_gid_hold",  32'(grant_id), 32'h0);
    next_cyc(); mid_cyc();
    check("io_rvalid_c3", 32'(rvalid),   32'h0);

    // IO and LS together: IO first, LS next; read returns in the same order.
    next_cyc();
    req = 4'b0011;
    addr[RQ_IO*AW +: AW] = 10'h020; addr[RQ_LS*AW +: AW] = 10'h030;
    mid_cyc(); check("iols_ack_c0", 32'(ack), 32'h1);
    next_cyc(); req = 4'b0010;
    mid_cyc();
    check("iols_ack_c1",  32'(ack),      32'h2);
    check("iols_addr_c1", 32'(ram_addr), 32'h020);
    next_cyc(); req = 4'b0000;
    mid_cyc();
    check("iols_rv_c2",   32'(rvalid),   32'h1);
    check("iols_addr_c2", 32'(ram_addr), 32'h030);
    check("iols_gid_c2",  32'(grant_id), 32'h1);
    next_cyc(); mid_cyc();
    check("iols_rv_c3",   32'(rvalid),   32'h2);
    idle(2);

    // LS locked two-beat write while IO requests continuously.
    req = 4'b0010; we = 4'b0010; lock = 1'b1;
    addr[RQ_LS*AW +: AW] = 10'h100; wdata[RQ_LS*32 +: 32] = 32'hA5A5_0001; be[RQ_LS*4 +: 4] = 4'b0011;
    mid_cyc(); check("lk_ack_b0", 32'(ack), 32'h2);
    next_cyc();
    req = 4'b0011; addr[RQ_IO*AW +: AW] = 10'h040;
    addr[RQ_LS*AW +: AW] = 10'h101; wdata[RQ_LS*32 +: 32] = 32'hA5A5_0002; be[RQ_LS*4 +: 4] = 4'b1100;
    mid_cyc();
    check("lk_ack_b1",   32'(ack),       32'h2);
    check("lk_we_b0",    32'(ram_we),    32'h1);
    check("lk_addr_b0",  32'(ram_addr),  32'h100);
    check("lk_be_b0",    32'(ram_be),    32'h3);
    check("lk_wdata_b0", ram_wdata,      32'hA5A5_0001);
    next_cyc();
    mid_cyc();
    check("lk_ack_io",   32'(ack),       32'h1);
    check("lk_addr_b1",  32'(ram_addr),  32'h101);
    check("lk_be_b1",    32'(ram_be),    32'hC);
    check("lk_wdata_b1", ram_wdata,      32'hA5A5_0002);
    check("lk_rv_b1",    32'(rvalid),    32'h0);
    next_cyc(); req = 4'b0000; we = 4'b0000; lock = 1'b0;
    mid_cyc();
    check("lk_io_addr",  32'(ram_addr),  32'h040);
    check("lk_io_we",    32'(ram_we),    32'h0);
    check("lk_io_be",    32'(ram_be),    32'hF);
    check("lk_rv_wr",    32'(rvalid),    32'h0);
    next_cyc(); mid_cyc();
    check("lk_io_rv",    32'(rvalid),    32'h1);
    idle(2);

    // PF and BL only: strict alternation starting at PF (rr reset value).
    req = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      exp_ack = (k % 2 == 0) ? 4'b0100 : 4'b1000;
      mid_cyc(); check($sformatf("rr_ack_%0d", k), 32'(ack), 32'(exp_ack));
      next_cyc();
    end
    idle(2);

    // Aging: LS every cycle, PF/BL held. PF ages to 8 by cycle 8; BL is aged too
    // and wins the following cycle since rr has moved to BL.
    req = 4'b1110;
    for (int k = 0; k <= 10; k++) begin
      exp_ack = (k == 8) ? 4'b0100 : (k == 9) ? 4'b1000 : 4'b0010;
      mid_cyc(); check($sformatf("age_ack_%0d", k), 32'(ack), 32'(exp_ack));
      next_cyc();
    end
    idle(2);

    // Reset one cycle after an IO read ack; rr left at BL beforehand.
    req = 4'b0100;
    mid_cyc(); check("rs_pf_ack", 32'(ack), 32'h4);
    next_cyc();
    req = 4'b0001; addr[RQ_IO*AW +: AW] = 10'h055;
    mid_cyc(); check("rs_io_ack", 32'(ack), 32'h1);
    next_cyc();
    req = 4'b0000;
    reset_n = 1'b0;
    #1;
    check("rs_cs",     32'(ram_cs),   32'h0);
    check("rs_addr",   32'(ram_addr), 32'h0);
    check("rs_be",     32'(ram_be),   32'h0);
    check("rs_gid",    32'(grant_id), 32'h0);
    check("rs_rv",     32'(rvalid),   32'h0);
    req = 4'b1111;
    #1;
    check("rs_ack",    32'(ack),      32'h0);
    next_cyc();
    check("rs_rv_sup", 32'(rvalid),   32'h0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    req = 4'b0000;
    next_cyc();
    req = 4'b1100;
    mid_cyc(); check("rs_rr_pf", 32'(ack), 32'h4);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
